// File: rtl/serial_bus_pkg.sv
// Shared encodings for the serial system bus: slave FSM states, op codes and bit order.
// Imported by the slave, and by the master and arbiter that sit on the same bus.
package serial_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ADDR   = 3'd1;
    localparam state_t ST_WDATA  = 3'd2;
    localparam state_t ST_COMMIT = 3'd3;
    localparam state_t ST_RDMEM  = 3'd4;
    localparam state_t ST_TX     = 3'd5;
    localparam state_t ST_DRAIN  = 3'd6;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Every serial field on the bus (address, write data, read data) travels LSB first.
    localparam bit LSB_FIRST = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM with one-cycle registered read.
// Contents are deliberately not reset.
module slave_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_AW     = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MEM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/serial_bus_slave.sv
// Serial bus slave: bit-serial address/write-data receive, ID and range decode,
// and a back-pressured bit-serial read return from local memory.
module serial_bus_slave
    import serial_bus_pkg::*;
#(
    parameter int                        ADDR_WIDTH     = 12,
    parameter int                        SLAVE_ID_WIDTH = 2,
    parameter logic [SLAVE_ID_WIDTH-1:0] SLAVE_ID       = 2'b10,
    parameter int                        DATA_WIDTH     = 8,
    parameter int                        MEM_DEPTH      = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    input  logic master_ready,
    input  logic rx_address,
    input  logic rx_data,
    output logic slave_ready,
    output logic slave_valid,
    output logic tx_data,
    output logic addr_err
);

    localparam int LOCAL_WIDTH = ADDR_WIDTH - SLAVE_ID_WIDTH;
    localparam int MEM_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_WIDTH   = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);

    localparam logic [CNT_WIDTH-1:0]   ADDR_LAST   = CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]   DATA_LAST   = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [LOCAL_WIDTH:0]   DEPTH_LIMIT = (LOCAL_WIDTH + 1)'(MEM_DEPTH);

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                    op_reg, op_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic [DATA_WIDTH-1:0]   tx_reg, tx_next;
    logic                    addr_err_reg, addr_err_next;

    logic [ADDR_WIDTH-1:0]   addr_shift;
    logic [DATA_WIDTH-1:0]   data_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic                    tx_bit;
    logic                    addr_hit;
    logic                    mem_we;
    logic [MEM_AW-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign addr_shift = LSB_FIRST ? {rx_address, addr_reg[ADDR_WIDTH-1:1]}
                                  : {addr_reg[ADDR_WIDTH-2:0], rx_address};
    assign data_shift = LSB_FIRST ? {rx_data, data_reg[DATA_WIDTH-1:1]}
                                  : {data_reg[DATA_WIDTH-2:0], rx_data};
    assign tx_shift   = LSB_FIRST ? {1'b0, tx_reg[DATA_WIDTH-1:1]}
                                  : {tx_reg[DATA_WIDTH-2:0], 1'b0};
    assign tx_bit     = LSB_FIRST ? tx_reg[0] : tx_reg[DATA_WIDTH-1];

    // Decode looks at the address including the bit arriving this cycle.
    assign addr_hit = (addr_shift[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH] == SLAVE_ID) &&
                      ({1'b0, addr_shift[LOCAL_WIDTH-1:0]} < DEPTH_LIMIT);

    // Reads are launched on the final address edge so the word is ready in RDMEM;
    // COMMIT uses the address already held in addr_reg.
    assign mem_we   = (state_reg == ST_COMMIT);
    assign mem_addr = mem_we ? addr_reg[MEM_AW-1:0] : addr_shift[MEM_AW-1:0];

    slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_AW     (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (data_reg),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        tx_next       = tx_reg;
        addr_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (master_valid) begin
                    if (read_en ^ write_en) begin
                        op_next    = write_en ? OP_WRITE : OP_READ;
                        cnt_next   = '0;
                        state_next = ST_ADDR;
                    end else begin
                        addr_err_next = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                addr_next = addr_shift;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_LAST) begin
                    cnt_next      = '0;
                    addr_err_next = !addr_hit;
                    if (op_reg == OP_WRITE) begin
                        state_next = addr_hit ? ST_WDATA : ST_DRAIN;
                    end else begin
                        state_next = addr_hit ? ST_RDMEM : ST_IDLE;
                    end
                end
            end
            ST_WDATA, ST_DRAIN: begin
                if (state_reg == ST_WDATA) begin
                    data_next = data_shift;
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == DATA_LAST) begin
                    cnt_next   = '0;
                    state_next = (state_reg == ST_WDATA) ? ST_COMMIT : ST_IDLE;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            ST_RDMEM: begin
                tx_next    = mem_rdata;
                state_next = ST_TX;
            end
            ST_TX: begin
                if (master_ready) begin
                    tx_next  = tx_shift;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == DATA_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            op_reg       <= OP_READ;
            addr_reg     <= '0;
            data_reg     <= '0;
            tx_reg       <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            tx_reg       <= tx_next;
            addr_err_reg <= addr_err_next;
        end
    end

    assign slave_ready = (state_reg == ST_IDLE);
    assign slave_valid = (state_reg == ST_TX);
    assign tx_data     = slave_valid & tx_bit;
    assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_serial_bus_slave.sv
// Randomised scoreboard bench for serial_bus_slave: a behavioural memory model feeds
// expected read bits and error-pulse cycles to queues that a separate monitor drains.
module tb_serial_bus_slave;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic read_en = 1'b0, write_en = 1'b0, master_valid = 1'b0, master_ready = 1'b0;
    logic rx_address = 1'b0, rx_data = 1'b0;
    logic slave_ready, slave_valid, tx_data, addr_err;

    int checks = 0;
    int passes = 0;
    int cyc_cnt = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic          exp_bits [$];
    int            exp_err_cyc [$];

    serial_bus_slave dut (
        .clk          (clk),
        .reset        (reset),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .tx_data      (tx_data),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 90000", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc_cnt);
    endtask

    // Higher-level decode: address = ID * 1024 + local word index.
    function automatic bit model_hit(input int a);
        return ((a / 1024) == 2) && ((a % 1024) < DEPTH);
    endfunction

    function automatic logic ready_bit(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            master_valid = 1'b0;
            read_en      = 1'($urandom_range(0, 1));
            write_en     = 1'($urandom_range(0, 1));
            rx_address   = 1'($urandom_range(0, 1));
            rx_data      = 1'($urandom_range(0, 1));
            master_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an accepted bit or an error pulse.
    initial begin
        logic b;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (slave_valid && master_ready) begin
                    if (exp_bits.size() == 0) check("tx_unexpected", slave_valid, 0);
                    else begin
                        b = exp_bits.pop_front();
                        check("tx_bit", tx_data, b);
                    end
                end
                if (addr_err) begin
                    if (exp_err_cyc.size() == 0) check("err_unexpected", addr_err, 0);
                    else check("err_cycle", cyc_cnt, exp_err_cyc.pop_front());
                end
            end
        end
    end

    task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int mode);
        bit legal, hit;
        int start, acc, vcyc, first_v, last_acc, end_c, local_a;
        legal = (rd != wr);
        hit = model_hit(int'(addr));
        local_a = int'(addr) % 1024;
        acc = 0; vcyc = 0; first_v = -1; last_acc = -1; end_c = -1; start = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                start = cyc_cnt;
                if (!legal) exp_err_cyc.push_back(start + 1);
                else if (!hit) exp_err_cyc.push_back(start + AW + 1);
                if (legal && rd && hit)
                    for (int i = 0; i < DW; i++) exp_bits.push_back(ref_mem[local_a][i]);
            end
            master_valid = (c == 0) ? 1'b1 : ((c <= AW) ? 1'($urandom_range(0, 1)) : 1'b0);
            read_en      = (c == 0) ? rd : 1'($urandom_range(0, 1));
            write_en     = (c == 0) ? wr : 1'($urandom_range(0, 1));
            rx_address   = (c >= 1 && c <= AW) ? addr[c-1] : 1'($urandom_range(0, 1));
            rx_data      = (wr && c > AW && c <= AW + DW) ? data[c-AW-1] : 1'($urandom_range(0, 1));
            master_ready = (c >= AW + 2) ? ready_bit(mode, c - AW - 2) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (slave_valid) begin
                vcyc++;
                if (first_v < 0) first_v = c;
            end
            if (slave_valid && master_ready) begin
                acc++;
                last_acc = c;
            end
            if (slave_ready && c >= (legal ? 1 : 0)) begin
                end_c = c;
                break;
            end
        end
        check("txn_completed", (end_c >= 0), 1);
        if (legal && wr && hit) begin
            check("wr_ready_latency", end_c, AW + DW + 2);
            ref_mem[local_a] = data;
        end else if (legal && wr) begin
            check("drain_ready_latency", end_c, AW + DW + 1);
        end else if (legal && !hit) begin
            check("rdmiss_ready_latency", end_c, AW + 1);
        end else if (legal) begin
            check("rd_first_valid", first_v, AW + 2);
            check("rd_bits_accepted", acc, DW);
            check("rd_ready_latency", end_c, last_acc + 1);
            if (mode == 0) check("rd_valid_cycles", vcyc, DW);
        end
        if (!(legal && rd && hit)) check("no_slave_valid", vcyc, 0);
        $display("txn cyc=%0d rd=%0b wr=%0b addr=%03h data=%02h mode=%0d end=%0d", start, rd, wr,
                 addr, data, mode, end_c);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic          r, w;
        int            k;

        reset = 1'b1;
        idle(3);
        @(negedge clk);
        check("rst_slave_ready", slave_ready, 1);
        check("rst_slave_valid", slave_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_addr_err", addr_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        @(negedge clk);
        check("idle_slave_ready", slave_ready, 1);
        check("idle_slave_valid", slave_valid, 0);

        for (int i = 0; i < DEPTH; i++) run_txn(1'b0, 1'b1, {2'b10, 2'b00, 8'(i)}, 8'($urandom), 0);
        run_txn(1'b0, 1'b1, 12'h805, 8'hA5, 0);
        run_txn(1'b1, 1'b0, 12'h805, 8'h00, 0);
        run_txn(1'b1, 1'b0, 12'h805, 8'h00, 1);
        run_txn(1'b0, 1'b1, 12'hADD, 8'h3C, 0);
        for (int i = 0; i < DEPTH; i++)
            run_txn(1'b1, 1'b0, {2'b10, 2'b00, 8'(i)}, 8'h00, $urandom_range(0, 2));
        run_txn(1'b1, 1'b0, 12'h405, 8'h00, 0);
        run_txn(1'b1, 1'b1, 12'h805, 8'h00, 0);
        run_txn(1'b0, 1'b1, 12'h806, 8'h5A, 0);
        run_txn(1'b0, 1'b0, 12'h805, 8'h00, 0);
        run_txn(1'b1, 1'b0, 12'h806, 8'h00, 0);

        // Abort a write partway through its address phase with an async reset.
        @(posedge clk); #1;
        master_valid = 1'b1; write_en = 1'b1; read_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            master_valid = 1'b0;
            rx_address = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("busy_before_reset", slave_ready, 0);
        #1 reset = 1'b1;
        #1;
        check("midrst_slave_ready", slave_ready, 1);
        check("midrst_slave_valid", slave_valid, 0);
        check("midrst_addr_err", addr_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        run_txn(1'b1, 1'b0, 12'h805, 8'h00, 0);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            a = (k < 7) ? {2'b10, 2'b00, 8'($urandom)} : 12'($urandom);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                r = 1'($urandom_range(0, 1));
                w = r;
            end else begin
                w = (k < 5);
                r = !w;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            run_txn(r, w, a, 8'($urandom), $urandom_range(0, 2));
        end

        idle(4);
        @(negedge clk);
        check("exp_bits_drained", exp_bits.size(), 0);
        check("exp_err_drained", exp_err_cyc.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
